// File: rtl/seq_mult_datapath.sv
// seq_mult_datapath
// WIDTH-bit register file of NREGS entries plus a shift-and-add multiplier.
// A start command reads reg[src_a] (multiplicand) and reg[src_b] (multiplier).
// It runs WIDTH add/shift steps and writes the 2*WIDTH-bit product back into
// reg[dst_lo] (low half) and reg[dst_hi] (high half).
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   wr_en/addr/data    host write port (honoured only while idle)
//   rd_addr, rd_data   combinational host read port
//   start              multiply request (sampled only while idle)
//   src_a, src_b       operand register addresses
//   dst_lo, dst_hi     product destination register addresses
//   busy               high from start acceptance until the writeback edge
//   done               one-cycle pulse after the writeback edge
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; host owns the register file
// CALC  | WIDTH add/shift steps over {acc_hi, mplr}
// WB    | write product halves back, raise done, return to IDLE

`timescale 1ns/1ps

module seq_mult_datapath #(
    parameter int WIDTH  = 8,
    parameter int NREGS  = 5,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_a,
    input  logic [ADDR_W-1:0] src_b,
    input  logic [ADDR_W-1:0] dst_lo,
    input  logic [ADDR_W-1:0] dst_hi,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_WB
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   regs_q [NREGS];
    logic [WIDTH-1:0]   regs_d [NREGS];
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplr_q, mplr_d;
    logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  dst_lo_q, dst_lo_d;
    logic [ADDR_W-1:0]  dst_hi_q, dst_hi_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   pp;
    logic [WIDTH:0]     sum;

    // Address decode by comparison so out-of-range addresses read as zero
    // without ever indexing past the end of the array.
    always_comb begin
        rd_data = '0;
        op_a    = '0;
        op_b    = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (rd_addr == ADDR_W'(i)) rd_data = regs_q[i];
            if (src_a   == ADDR_W'(i)) op_a    = regs_q[i];
            if (src_b   == ADDR_W'(i)) op_b    = regs_q[i];
        end
    end

    always_comb begin
        state_d  = state_q;
        regs_d   = regs_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        acc_hi_d = acc_hi_q;
        cnt_d    = cnt_q;
        dst_lo_d = dst_lo_q;
        dst_hi_d = dst_hi_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pp       = '0;
        sum      = '0;

        case (state_q)
            ST_IDLE: begin
                // Operands come from regs_q, so a same-edge host write is
                // not seen by the multiply it coincides with.
                for (int i = 0; i < NREGS; i++) begin
                    if (wr_en && (wr_addr == ADDR_W'(i))) regs_d[i] = wr_data;
                end
                if (start) begin
                    mcand_d  = op_a;
                    mplr_d   = op_b;
                    dst_lo_d = dst_lo;
                    dst_hi_d = dst_hi;
                    acc_hi_d = '0;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_CALC;
                end
            end

            ST_CALC: begin
                // mplr doubles as the low product half: each step shifts the
                // sum LSB in at the top while consuming one multiplier bit.
                pp       = mcand_q & {WIDTH{mplr_q[0]}};
                sum      = {1'b0, acc_hi_q} + {1'b0, pp};
                acc_hi_d = sum[WIDTH:1];
                mplr_d   = {sum[0], mplr_q[WIDTH-1:1]};
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_WB;
            end

            ST_WB: begin
                // High half written last so it wins when dst_lo == dst_hi.
                for (int i = 0; i < NREGS; i++) begin
                    if (dst_lo_q == ADDR_W'(i)) regs_d[i] = mplr_q;
                end
                for (int i = 0; i < NREGS; i++) begin
                    if (dst_hi_q == ADDR_W'(i)) regs_d[i] = acc_hi_q;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            mcand_q  <= '0;
            mplr_q   <= '0;
            acc_hi_q <= '0;
            cnt_q    <= '0;
            dst_lo_q <= '0;
            dst_hi_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
            mcand_q  <= mcand_d;
            mplr_q   <= mplr_d;
            acc_hi_q <= acc_hi_d;
            cnt_q    <= cnt_d;
            dst_lo_q <= dst_lo_d;
            dst_hi_q <= dst_hi_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_seq_mult_datapath.sv
// tb_seq_mult_datapath
// Scoreboard bench for seq_mult_datapath (WIDTH=8, NREGS=5, ADDR_W=3).
// The stimulus side keeps an arithmetic model of the register file.
// Each command pushes the expected done cycle and the full expected register
// image. The monitor pops one entry per done pulse and reads back all
// eight addresses through rd_addr.

`timescale 1ns/10ps

module tb_seq_mult_datapath;

    localparam int WIDTH  = 8;
    localparam int NREGS  = 5;
    localparam int ADDR_W = 3;

    typedef struct packed {
        logic [7:0][7:0] regs;
        logic [31:0]     cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data;
    logic              start;
    logic [ADDR_W-1:0] src_a, src_b, dst_lo, dst_hi;
    logic              busy;
    logic              done;

    int              n_checks = 0;
    int              n_pass   = 0;
    int              cyc      = 0;
    logic [7:0][7:0] model;
    exp_t            sb_q[$];

    seq_mult_datapath #(.WIDTH(WIDTH), .NREGS(NREGS), .ADDR_W(ADDR_W)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .start   (start),
        .src_a   (src_a),
        .src_b   (src_b),
        .dst_lo  (dst_lo),
        .dst_hi  (dst_hi),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        if (a < NREGS) model[a] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // no_wait: drive start at the current negedge (used right after done).
    // do_wr: host write in the same cycle as start.
    // glitch: busy-cycle index at which start/wr_en are pulsed mid-operation.
    task automatic run_mul(input logic [2:0] sa, input logic [2:0] sb,
                           input logic [2:0] dl, input logic [2:0] dh,
                           input bit no_wait, input bit do_wr,
                           input logic [2:0] wa, input logic [7:0] wd,
                           input int glitch);
        exp_t        e;
        logic [15:0] p;
        int          nb;
        if (!no_wait) @(negedge clk);
        start  = 1'b1;
        src_a  = sa;
        src_b  = sb;
        dst_lo = dl;
        dst_hi = dh;
        if (do_wr) begin
            wr_en   = 1'b1;
            wr_addr = wa;
            wr_data = wd;
        end
        p = 16'(model[sa]) * 16'(model[sb]);
        if (do_wr && wa < NREGS) model[wa] = wd;
        if (dl < NREGS) model[dl] = p[7:0];
        if (dh < NREGS) model[dh] = p[15:8];
        e.regs = model;
        e.cyc  = 32'(cyc + WIDTH + 2);
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        wr_en = 1'b0;
        nb = 0;
        while (busy && nb < 40) begin
            nb++;
            if (nb == glitch) begin
                start   = 1'b1;
                src_a   = 3'($urandom_range(0, 4));
                src_b   = 3'($urandom_range(0, 4));
                dst_lo  = 3'd0;
                dst_hi  = 3'd0;
                wr_en   = 1'b1;
                wr_addr = 3'd0;
                wr_data = 8'hAA;
            end else begin
                start = 1'b0;
                wr_en = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        wr_en = 1'b0;
        check("busy_cycles", 32'(nb), 32'(WIDTH + 1));
    endtask

    // Monitor: owns rd_addr; one scoreboard entry per done pulse.
    initial begin
        exp_t e;
        rd_addr = '0;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                check("done_expected", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("done_cycle", 32'(cyc), e.cyc);
                    check("busy_at_done", 32'(busy), 32'd0);
                    for (int a = 0; a < 8; a++) begin
                        rd_addr = 3'(a);
                        #0.5;
                        check($sformatf("rd_reg%0d", a), 32'(rd_data), 32'(e.regs[a]));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nwait;
        model   = '0;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        src_a   = '0;
        src_b   = '0;
        dst_lo  = '0;
        dst_hi  = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst = 1'b0;

        // Basic product, then carry into the acc_hi MSB, then zero multiplier
        write_reg(3'd0, 8'd3);
        write_reg(3'd1, 8'd5);
        run_mul(3'd0, 3'd1, 3'd2, 3'd3, 0, 0, 3'd0, 8'd0, 0);
        write_reg(3'd0, 8'hFF);
        write_reg(3'd1, 8'hFF);
        run_mul(3'd0, 3'd1, 3'd2, 3'd3, 0, 0, 3'd0, 8'd0, 0);
        write_reg(3'd1, 8'h00);
        run_mul(3'd0, 3'd1, 3'd2, 3'd3, 0, 0, 3'd0, 8'd0, 0);

        // Destinations alias sources; then dst_lo == dst_hi
        write_reg(3'd0, 8'h80);
        write_reg(3'd1, 8'h02);
        run_mul(3'd0, 3'd1, 3'd0, 3'd1, 0, 0, 3'd0, 8'd0, 0);
        write_reg(3'd0, 8'h80);
        write_reg(3'd1, 8'h02);
        run_mul(3'd0, 3'd1, 3'd4, 3'd4, 0, 0, 3'd0, 8'd0, 0);

        // start and wr_en pulsed mid-CALC must be ignored
        write_reg(3'd0, 8'd3);
        write_reg(3'd1, 8'd5);
        run_mul(3'd0, 3'd1, 3'd2, 3'd3, 0, 0, 3'd0, 8'd0, 4);

        // Reset at edge 4 of a multiply aborts it: no writeback, no done
        write_reg(3'd0, 8'd3);
        write_reg(3'd1, 8'd5);
        @(negedge clk);
        start  = 1'b1;
        src_a  = 3'd0;
        src_b  = 3'd1;
        dst_lo = 3'd2;
        dst_hi = 3'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        rst   = 1'b0;
        model = '0;
        repeat (15) @(negedge clk);
        write_reg(3'd0, 8'd7);
        write_reg(3'd1, 8'd9);
        run_mul(3'd0, 3'd1, 3'd2, 3'd3, 0, 0, 3'd0, 8'd0, 0);

        // Out-of-range write dropped, out-of-range source reads 0,
        // out-of-range dst_hi dropped
        write_reg(3'd7, 8'h55);
        run_mul(3'd6, 3'd1, 3'd2, 3'd3, 0, 0, 3'd0, 8'd0, 0);
        run_mul(3'd0, 3'd1, 3'd4, 3'd7, 0, 0, 3'd0, 8'd0, 0);

        // Same-edge host write and start: operands use pre-write contents
        run_mul(3'd0, 3'd1, 3'd2, 3'd3, 0, 1, 3'd0, 8'h10, 0);

        // Start accepted on the edge where done is high
        write_reg(3'd1, 8'hC3);
        run_mul(3'd0, 3'd1, 3'd2, 3'd3, 0, 0, 3'd0, 8'd0, 0);
        run_mul(3'd2, 3'd3, 3'd4, 3'd0, 1, 0, 3'd0, 8'd0, 0);

        // Randomized commands
        for (int i = 0; i < 25; i++) begin
            bit bb;
            bb = (i % 4 == 1);
            if (!bb) begin
                for (int k = 0; k < int'($urandom_range(0, 2)); k++)
                    write_reg(3'($urandom_range(0, 7)), 8'($urandom));
            end
            run_mul(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    bb, (i % 3 == 0), 3'($urandom_range(0, 7)), 8'($urandom), 0);
        end

        nwait = 0;
        while (sb_q.size() > 0 && nwait < 30) begin
            nwait++;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        check("queue_drained", 32'(sb_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_mult_datapath.md
Name: seq_mult_datapath

Overview:
Parametrised successor to the single-bit multiplier slice. It provides a WIDTH-bit register file of NREGS entries together with a partial-product generator (multiplicand AND multiplier LSB), a ripple adder and a shift-and-add controller. One start command multiplies two registers and writes the 2*WIDTH-bit product back into two destination registers. It sits under the top-level sequencer, which loads operands, issues start, waits for done and reads results.

Parameters:
WIDTH, 8, data width of each register and of each operand
NREGS, 5, number of register-file entries
ADDR_W, 3, register address width; must satisfy 2**ADDR_W >= NREGS

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
wr_en  input  1  host write strobe
wr_addr  input  ADDR_W  host write address
wr_data  input  WIDTH  host write data
rd_addr  input  ADDR_W  host read address
rd_data  output  WIDTH  combinational read of reg[rd_addr]
start  input  1  multiply request, sampled only in IDLE
src_a  input  ADDR_W  multiplicand register
src_b  input  ADDR_W  multiplier register
dst_lo  input  ADDR_W  destination register for product[WIDTH-1:0]
dst_hi  input  ADDR_W  destination register for product[2*WIDTH-1:WIDTH]
busy  output  1  high from the start-accept edge until the writeback edge
done  output  1  one-cycle pulse following the writeback edge

Behaviour:
- Reset (rst high at an edge): all registers go to 0, state goes to IDLE, busy=0, done=0, iteration count=0. Reset wins over every other input.
- Reset mid-operation aborts the multiply. There is no writeback and no done pulse.
- State machine: IDLE -> CALC -> WB -> IDLE.
- IDLE, start=1 at edge 0:
  - Latch mcand=reg[src_a], mplr=reg[src_b].
  - Latch dst_lo/dst_hi.
  - Set acc_hi=0, cnt=0, busy=1, next state CALC.
- CALC, each edge (WIDTH edges total, edges 1..WIDTH):
  - Compute pp = mcand AND {WIDTH{mplr[0]}}.
  - Compute {c, sum} = acc_hi + pp, which is WIDTH+1 bits.
  - Shift {c, sum, mplr} right by one: the new acc_hi is {c, sum[WIDTH-1:1]}, and the new mplr is {sum[0], mplr[WIDTH-1:1]}.
  - Increment cnt. When cnt reaches WIDTH-1 on this edge, next state is WB.
- WB, edge WIDTH+1:
  - Write reg[dst_lo]=mplr (low half) and reg[dst_hi]=acc_hi (high half).
  - Set busy=0, done=1, next state IDLE.
- done is high for exactly one cycle after the WB edge and is cleared on the next edge.
- Latency: start accepted at edge 0; results visible on rd_data after edge WIDTH+1.
- A new start may be accepted on the edge where done is high.
- dst_lo == dst_hi: the high half is written; the low half is discarded.
- Source/destination aliasing is legal. Operands are latched at start, so writeback never corrupts the computation.
- start while busy: ignored, with no queueing.
- wr_en while busy (CALC or WB): ignored; the register file is owned by the engine.
- wr_en and start in the same IDLE edge:
  - The host write is performed.
  - Operands read the pre-write register contents.
- Out-of-range address (>= NREGS):
  - A write is dropped.
  - rd_data and operand reads return 0.
  - A writeback to that destination is dropped.
- Arithmetic is unsigned. The product is exact for all operands; no overflow is possible within 2*WIDTH bits.

Test Plan:
- WIDTH=8. rst, then write reg0=3, reg1=5; start with src_a=0, src_b=1, dst_lo=2, dst_hi=3 -> busy for 9 cycles, done pulses after edge 9, reg2=15, reg3=0, reg0/reg1 unchanged.
- reg0=0xFF, reg1=0xFF, same command -> reg2=0x01, reg3=0xFE (checks carry into acc_hi MSB); then reg1=0x00 -> reg2=0, reg3=0.
- Aliasing: reg0=0x80, reg1=0x02, src_a=0, src_b=1, dst_lo=0, dst_hi=1 -> reg0=0x00, reg1=0x01. Second case, dst_lo=dst_hi=4 -> reg4=0x01.
- Interference during CALC: pulse start and wr_en (wr_addr=0, wr_data=0xAA) mid-CALC -> no second operation, reg0 unaffected, exactly one done pulse at the normal time.
- rst asserted at edge 4 of a 3*5 multiply -> busy=0 and done=0 after that edge, no done pulse ever appears; a new 7*9 multiply afterwards yields 63/0 with normal latency.
- Out-of-range: wr_addr=7 write then rd_addr=7 -> rd_data=0. src_a=6 -> product 0 written. dst_hi=7 -> only dst_lo is written.
